// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pulls one word per frame from a TX FIFO and
// serialises it as start bit, DataWidth data bits (LSB first) and a stop bit.
module uart_tx_ctrl #(
  parameter int DataWidth = 8,
  parameter int BaudDiv   = 868
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 fifo_empty_i,
  input  logic [DataWidth-1:0] fifo_rd_data_i,
  output logic                 fifo_rd_en_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int DivWidth = $clog2(BaudDiv);
  localparam int BitWidth = $clog2(DataWidth + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [DivWidth-1:0]    baud_q, baud_d;
  logic [BitWidth-1:0]    bit_q, bit_d;
  logic [DataWidth-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;

  logic baud_end;
  logic last_bit;

  assign baud_end = (baud_q == DivWidth'(BaudDiv - 1));
  assign last_bit = (bit_q == BitWidth'(DataWidth - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        // The empty flag only matters here; once FETCH is entered the read is committed.
        if (en_i && !fifo_empty_i) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = fifo_rd_data_i;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + DivWidth'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (last_bit) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BitWidth'(1);
          end
        end else begin
          baud_d = baud_q + DivWidth'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + DivWidth'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level is registered, so it is derived from where the FSM is going next.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign fifo_rd_en_o = (state_q == FETCH);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == STOP) && baud_end;
  assign tx_o         = tx_q;

endmodule
